// File: rtl/freq_adjust_pkg.sv
// Shared state encoding, default parameters and a saturating-count helper
// for the frequency-adjust pulse receiver.
package freq_adjust_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_HOLDOFF,
    ST_WAIT_LOW
  } rxState_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_PULSE   = 4;
  localparam int DEF_HOLDOFF     = 16;
  localparam int DEF_ACC_WIDTH   = 16;

  function automatic logic [7:0] satIncr(input logic [7:0] value, input logic [1:0] amount);
    logic [8:0] sum;
    sum = {1'b0, value} + {7'd0, amount};
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/freq_adjust_receiver_if.sv
// Pin, control and result bundle of the receiver; the block owns the results
// (slave), the surrounding logic drives the pins and clear (master).
interface freq_adjust_receiver_if
  import freq_adjust_pkg::*;
#(
   parameter int ACC_WIDTH = DEF_ACC_WIDTH
) ();

   logic                        finc;
   logic                        fdec;
   logic                        clear;
   logic                        step_valid;
   logic                        step_dir;
   logic signed [ACC_WIDTH-1:0] accum;
   logic [7:0]                  reject_count;
   logic                        conflict;

   modport master (
      output finc, fdec, clear,
      input  step_valid, step_dir, accum, reject_count, conflict
   );

   modport slave (
      input  finc, fdec, clear,
      output step_valid, step_dir, accum, reject_count, conflict
   );

endinterface

// File: rtl/pin_sync.sv
// Single-bit multi-flop synchronizer bringing an asynchronous pin into clk.
module pin_sync
  import freq_adjust_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic pinSync
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stages <= '0;
      else     stages <= (stages << 1) | SYNC_STAGES'(pin);
   end

   assign pinSync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/freq_adjust_receiver.sv
// Qualifies FINC/FDEC pulses by width and holdoff, turning accepted pulses
// into step strobes and a saturating signed step accumulator.
module freq_adjust_receiver
  import freq_adjust_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int MIN_PULSE   = DEF_MIN_PULSE,
   parameter int HOLDOFF     = DEF_HOLDOFF,
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
   input logic             clk,
   input logic             rst,
   freq_adjust_receiver_if.slave bus
);

   localparam int WCNT_W = $clog2(MIN_PULSE + 1);
   localparam int HCNT_W = $clog2(HOLDOFF + 1);
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic fincS, fdecS, fincQ, fdecQ;
   rxState_t state;
   logic dirLatch;
   logic [WCNT_W-1:0] widthCnt;
   logic [HCNT_W-1:0] holdCnt;
   logic stepValidR, stepDirR, conflictR;
   logic signed [ACC_WIDTH-1:0] accumR, nextAccum;
   logic [7:0] rejectCnt;
   logic selPin, otherPin;
   logic [1:0] riseCount;

   pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncInc (.clk(clk), .rst(rst), .pin(bus.finc), .pinSync(fincS));
   pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncDec (.clk(clk), .rst(rst), .pin(bus.fdec), .pinSync(fdecS));

   always_comb begin
      selPin    = dirLatch ? fincS : fdecS;
      otherPin  = dirLatch ? fdecS : fincS;
      riseCount = {1'b0, fincS & ~fincQ} + {1'b0, fdecS & ~fdecQ};
      nextAccum = accumR;
      if (dirLatch && accumR != ACC_MAX)       nextAccum = accumR + 1'b1;
      else if (!dirLatch && accumR != ACC_MIN) nextAccum = accumR - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         fincQ      <= 1'b0;
         fdecQ      <= 1'b0;
         dirLatch   <= 1'b0;
         widthCnt   <= '0;
         holdCnt    <= '0;
         stepValidR <= 1'b0;
         stepDirR   <= 1'b0;
         accumR     <= '0;
         rejectCnt  <= '0;
         conflictR  <= 1'b0;
      end else begin
         stepValidR <= 1'b0;
         fincQ      <= fincS;
         fdecQ      <= fdecS;
         unique case (state)
            ST_IDLE: begin
               if (fincS && fdecS) begin
                  conflictR <= 1'b1;
                  state     <= ST_WAIT_LOW;
               end else if (fincS || fdecS) begin
                  dirLatch <= fincS;
                  widthCnt <= WCNT_W'(1);
                  state    <= ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               if (otherPin) begin
                  conflictR <= 1'b1;
                  state     <= ST_WAIT_LOW;
               end else if (selPin) begin
                  if (int'(widthCnt) < MIN_PULSE) widthCnt <= widthCnt + 1'b1;
               end else if (int'(widthCnt) >= MIN_PULSE) begin
                  stepValidR <= 1'b1;
                  stepDirR   <= dirLatch;
                  accumR     <= nextAccum;
                  holdCnt    <= '0;
                  state      <= ST_HOLDOFF;
               end else begin
                  rejectCnt <= satIncr(rejectCnt, 2'd1);
                  state     <= ST_IDLE;
               end
            end
            ST_HOLDOFF: begin
               rejectCnt <= satIncr(rejectCnt, riseCount);
               if (int'(holdCnt) == HOLDOFF - 1) state <= (fincS || fdecS) ? ST_WAIT_LOW : ST_IDLE;
               else                              holdCnt <= holdCnt + 1'b1;
            end
            ST_WAIT_LOW: begin
               if (!fincS && !fdecS) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         // NOTE: placed after the FSM so its non-blocking writes override any
         // same-cycle accept/reject update; step strobe and state are untouched.
         if (bus.clear) begin
            accumR    <= '0;
            rejectCnt <= '0;
            conflictR <= 1'b0;
         end
      end
   end

   assign bus.step_valid   = stepValidR;
   assign bus.step_dir     = stepDirR;
   assign bus.accum        = accumR;
   assign bus.reject_count = rejectCnt;
   assign bus.conflict     = conflictR;

endmodule
